// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bit 6 = a ... bit 0 = g) and capture FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLING,
      ST_CAPTURED
   } cap_state_t;

   function automatic logic one_low(input logic [3:0] an);
      return ($countones(~an) == 1);
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low segment pattern back to a BCD digit.
module seg7_to_bcd (
   input  logic [6:0] i_seg,
   output logic [3:0] o_digit,
   output logic       o_valid
);
   import seg7_pkg::*;

   always_comb begin
      o_digit = DIGIT_BLANK;
      o_valid = 1'b1;
      case (i_seg)
         SEG_0:     o_digit = 4'd0;
         SEG_1:     o_digit = 4'd1;
         SEG_2:     o_digit = 4'd2;
         SEG_3:     o_digit = 4'd3;
         SEG_4:     o_digit = 4'd4;
         SEG_5:     o_digit = 4'd5;
         SEG_6:     o_digit = 4'd6;
         SEG_7:     o_digit = 4'd7;
         SEG_8:     o_digit = 4'd8;
         SEG_9:     o_digit = 4'd9;
         SEG_BLANK: o_digit = DIGIT_BLANK;
         default:   o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitors a scanned an/seg display: synchronises, waits for each slot to settle,
// decodes the digit once per dwell and tracks frame completion, errors and stalls.
module seg_scan_capture #(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   input  logic       clr_err,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic [3:0] dig_valid,
   output logic       frame_done,
   output logic       err_seg,
   output logic       err_an,
   output logic       stale
);
   import seg7_pkg::*;

   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [3:0]    r_an_s1, r_an_s2;
   logic [6:0]    r_seg_s1, r_seg_s2;
   logic [10:0]   r_prev;
   logic [SW-1:0] r_settle;
   logic [TW-1:0] r_to;
   cap_state_t    r_state, w_state_nxt;
   logic [3:0]    r_d [4];
   logic [3:0]    r_dig_valid, r_seen;
   logic          r_frame_done, r_err_seg, r_err_an, r_stale;

   logic          w_change, w_capture, w_one_low, w_seg_ok, w_valid_cap, w_timeout;
   logic [3:0]    w_digit, w_onehot, w_seen_nxt, w_valid_base;
   logic [1:0]    w_idx;

   seg7_to_bcd u_dec (
      .i_seg   (r_seg_s2),
      .o_digit (w_digit),
      .o_valid (w_seg_ok)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_an_s1  <= 4'hF;
         r_an_s2  <= 4'hF;
         r_seg_s1 <= 7'h7F;
         r_seg_s2 <= 7'h7F;
         r_prev   <= {4'hF, 7'h7F};
      end else begin
         r_an_s1  <= an;
         r_an_s2  <= r_an_s1;
         r_seg_s1 <= seg;
         r_seg_s2 <= r_seg_s1;
         r_prev   <= {r_an_s2, r_seg_s2};
      end
   end

   assign w_change  = ({r_an_s2, r_seg_s2} != r_prev);
   assign w_one_low = one_low(r_an_s2);
   assign w_timeout = (r_to == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            r_settle <= '0;
      else if (w_change)                       r_settle <= '0;
      else if (r_settle != SW'(SETTLE_CYCLES)) r_settle <= r_settle + SW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Capture fires on the edge where the settle count reaches SETTLE_CYCLES-1,
   // so the decision is taken while it still reads SETTLE_CYCLES-2.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      if (w_change) begin
         w_state_nxt = (r_an_s2 == 4'hF) ? ST_IDLE : ST_SETTLING;
      end else if (r_state == ST_SETTLING && r_settle == SW'(SETTLE_CYCLES - 2)) begin
         w_state_nxt = ST_CAPTURED;
         w_capture   = 1'b1;
      end
   end

   always_comb begin
      w_idx = '0;
      for (int unsigned i = 0; i < 4; i++)
         if (!r_an_s2[i]) w_idx = 2'(i);
   end

   assign w_onehot     = 4'b0001 << w_idx;
   assign w_valid_cap  = w_capture && w_one_low && w_seg_ok;
   // A capture coinciding with the timeout starts a fresh frame rather than losing the slot.
   assign w_seen_nxt   = (w_timeout ? 4'b0000 : r_seen) | w_onehot;
   assign w_valid_base = w_timeout ? 4'b0000 : r_dig_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 4; i++) r_d[i] <= '0;
         r_dig_valid  <= '0;
         r_seen       <= '0;
         r_frame_done <= 1'b0;
         r_to         <= '0;
         r_stale      <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_valid_cap) begin
            r_d[w_idx]  <= w_digit;
            r_dig_valid <= w_valid_base | w_onehot;
            r_to        <= '0;
            r_stale     <= 1'b0;
            if (&w_seen_nxt) begin
               r_frame_done <= 1'b1;
               r_seen       <= '0;
            end else begin
               r_seen <= w_seen_nxt;
            end
         end else if (w_timeout) begin
            r_stale     <= 1'b1;
            r_dig_valid <= '0;
            r_seen      <= '0;
         end else begin
            r_to <= r_to + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_seg <= 1'b0;
         r_err_an  <= 1'b0;
      end else begin
         if (w_capture && w_one_low && !w_seg_ok) r_err_seg <= 1'b1;
         else if (clr_err)                        r_err_seg <= 1'b0;
         if (w_capture && !w_one_low)             r_err_an  <= 1'b1;
         else if (clr_err)                        r_err_an  <= 1'b0;
      end
   end

   assign d0         = r_d[0];
   assign d1         = r_d[1];
   assign d2         = r_d[2];
   assign d3         = r_d[3];
   assign dig_valid  = r_dig_valid;
   assign frame_done = r_frame_done;
   assign err_seg    = r_err_seg;
   assign err_an     = r_err_an;
   assign stale      = r_stale;

endmodule
